branch_pc_unit: RTL and testbench

Program-counter and control-transfer unit for the RV32 single-cycle core, generalised from the BEQ-only path. It owns the PC register, resolves all six B-type conditions plus JAL/JALR, and supports stall and a misaligned-target trap handshake. It sits between instruction fetch and the register file/ALU of `RiscV_SingleCycle`, and replaces the inline PC-update logic.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/branch_cmp.sv | 37 +++
 rtl/branch_pc_unit.sv | 143 ++++++++++++++
 tb/tb_branch_pc_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 control-transfer definitions: opcodes, branch funct3 codes
// and the PC-unit state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t RUN  = 1'b0;
    localparam state_t TRAP = 1'b1;

endpackage

// File: rtl/branch_cmp.sv
// B-type condition evaluator: decides taken/illegal from funct3 and the two
// register operands. Purely combinational.
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = ~lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = ~lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register and control-transfer resolution (B-type, JAL, JALR) with stall
// and misaligned-target trap handshake. BRANCH_STATS_EN adds branch counters.
//
// state | meaning
// RUN   | PC advances every unstalled cycle; misaligned taken target -> TRAP
// TRAP  | misaligned_trap high, PC frozen, stall ignored; trap_ack -> trap_vector
module branch_pc_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
`ifdef BRANCH_STATS_EN
    ,
    parameter int              STAT_W   = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              trap_ack,
    input  logic [XLEN-1:0]   trap_vector,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   link_addr,
    output logic              branch_taken,
    output logic              misaligned_trap,
    output logic [XLEN-1:0]   trap_pc,
    output logic              illegal_branch
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] taken_count
`endif
);

    state_t          state;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            misaligned;
    logic            cmp_taken;
    logic            cmp_illegal;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);

    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (funct3),
        .a       (rs1_data),
        .b       (rs2_data),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign pc_plus4  = pc + XLEN'(4);
    assign jalr_sum  = rs1_data + imm_i;
    assign link_addr = pc_plus4;

    always_comb begin
        redirect = 1'b0;
        target   = pc + imm_b;
        if (is_jal) begin
            redirect = 1'b1;
            target   = pc + imm_j;
        end else if (is_jalr) begin
            redirect = 1'b1;
            target   = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (is_branch) begin
            redirect = cmp_taken;
        end
    end

    // A misaligned target never redirects; it diverts into TRAP instead.
    assign misaligned      = redirect & (target[1:0] != 2'b00);
    assign branch_taken    = (state == RUN) & redirect & ~misaligned;
    assign illegal_branch  = is_branch & cmp_illegal;
    assign misaligned_trap = (state == TRAP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_PC;
            state   <= RUN;
            trap_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (misaligned) begin
                            state   <= TRAP;
                            trap_pc <= pc;
                        end else begin
                            pc <= branch_taken ? target : pc_plus4;
                        end
                    end
                end
                TRAP: begin
                    if (trap_ack) begin
                        pc    <= trap_vector;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic count_en;

    assign count_en = (state == RUN) & ~stall & is_branch & ~cmp_illegal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (count_en) begin
            if (~&branch_count) branch_count <= branch_count + STAT_W'(1);
            if (branch_taken && ~&taken_count) taken_count <= taken_count + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit; expectations are queued by the
// driver and checked by an independent monitor on the falling clock edge.
module tb_branch_pc_unit;

    localparam int XLEN = 32;

    localparam int S_PC  = 0;
    localparam int S_BT  = 1;
    localparam int S_LA  = 2;
    localparam int S_MT  = 3;
    localparam int S_TPC = 4;
    localparam int S_IL  = 5;
    localparam int S_BC  = 6;
    localparam int S_TC  = 7;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [31:0]     instruction;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            trap_ack;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link_addr;
    logic            branch_taken;
    logic            misaligned_trap;
    logic [XLEN-1:0] trap_pc;
    logic            illegal_branch;
`ifdef BRANCH_STATS_EN
    logic [31:0]     branch_count;
    logic [31:0]     taken_count;
`endif

    branch_pc_unit #(.XLEN(XLEN), .RESET_PC('0)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .instruction     (instruction),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .trap_ack        (trap_ack),
        .trap_vector     (trap_vector),
        .pc              (pc),
        .link_addr       (link_addr),
        .branch_taken    (branch_taken),
        .misaligned_trap (misaligned_trap),
        .trap_pc         (trap_pc),
        .illegal_branch  (illegal_branch)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count    (branch_count),
        .taken_count     (taken_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   mcyc  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [63:0] get_sig(input int sig);
        case (sig)
            S_PC:  return 64'(pc);
            S_BT:  return 64'(branch_taken);
            S_LA:  return 64'(link_addr);
            S_MT:  return 64'(misaligned_trap);
            S_TPC: return 64'(trap_pc);
            S_IL:  return 64'(illegal_branch);
`ifdef BRANCH_STATS_EN
            S_BC:  return 64'(branch_count);
            S_TC:  return 64'(taken_count);
`endif
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    // Monitor: compares every queued expectation that is due this cycle.
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= mcyc) begin
                e   = sb.pop_front();
                act = get_sig(e.sig);
                n_cmp++;
                if (e.cyc != mcyc || act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: actual %0h required %0h (cycle %0d)", e.name, act, e.exp, mcyc);
                end
            end
            mcyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_now(input int sig, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc = mcyc; e.sig = sig; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_next(input int sig, input logic [63:0] v, input string nm);
        exp_t e;
        e.cyc = mcyc + 1; e.sig = sig; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [12:0] v;
        v = imm[12:0];
        return {v[12], v[10:5], 5'd5, 5'd4, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] v;
        v = imm[20:0];
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input int imm);
        logic [11:0] v;
        v = imm[11:0];
        return {v, 5'd6, 3'b000, 5'd1, 7'b1100111};
    endfunction

    initial begin
        reset = 1'b0; stall = 1'b0; trap_ack = 1'b0; trap_vector = '0;
        instruction = NOP; rs1_data = '0; rs2_data = '0;
        tick();
        reset = 1'b1;
        exp_now(S_PC, 0, "reset_pc");
        exp_now(S_MT, 0, "reset_trap");
        exp_now(S_TPC, 0, "reset_trap_pc");
`ifdef BRANCH_STATS_EN
        exp_now(S_BC, 0, "reset_branch_count");
        exp_now(S_TC, 0, "reset_taken_count");
`endif

        instruction = enc_b(16, 3'b000); rs1_data = 10; rs2_data = 10;
        exp_now(S_BT, 1, "beq_taken");
        exp_now(S_LA, 4, "beq_link");
        exp_now(S_IL, 0, "beq_legal");
        exp_next(S_PC, 16, "beq_pc");
        tick();

        instruction = enc_b(16, 3'b001); rs1_data = 7; rs2_data = 7;
        exp_now(S_BT, 0, "bne_not_taken");
        exp_next(S_PC, 20, "bne_pc");
        tick();

        instruction = enc_b(-20, 3'b100); rs1_data = 32'hFFFF_FFF8; rs2_data = 3;
        exp_now(S_BT, 1, "blt_taken");
        exp_next(S_PC, 0, "blt_pc");
        tick();

        instruction = enc_b(-20, 3'b110);
        exp_now(S_BT, 0, "bltu_not_taken");
        exp_next(S_PC, 4, "bltu_pc");
        tick();

        instruction = enc_i(0); rs1_data = 32'h101;
        exp_now(S_BT, 1, "jalr_mask_taken");
        exp_next(S_PC, 32'h100, "jalr_mask_pc");
        tick();

        instruction = enc_j(-32'sh0C0);
        exp_next(S_PC, 32'h40, "jal_back_pc");
        tick();

        instruction = enc_i(3); rs1_data = 32'h101;
        exp_now(S_LA, 32'h44, "jalr_link");
        exp_next(S_PC, 32'h104, "jalr_pc");
        tick();

        instruction = enc_j(-32'sh104);
        exp_now(S_LA, 32'h108, "jal_link");
        exp_next(S_PC, 0, "jal_pc");
        tick();

        instruction = enc_j(32'h20);
        exp_next(S_PC, 32'h20, "jal_fwd_pc");
        tick();

        instruction = enc_b(6, 3'b000); rs1_data = 10; rs2_data = 10;
        exp_now(S_BT, 0, "misaligned_no_redirect");
        exp_next(S_MT, 1, "trap_entry");
        exp_next(S_TPC, 32'h20, "trap_pc");
        exp_next(S_PC, 32'h20, "trap_entry_pc");
        tick();

        instruction = enc_b(16, 3'b000);
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            tick();
            exp_now(S_PC, 32'h20, "trap_hold_pc");
            exp_now(S_MT, 1, "trap_hold");
            exp_now(S_BT, 0, "trap_no_taken");
        end
        stall = 1'b0;

        trap_ack = 1'b1; trap_vector = 32'h80;
        exp_next(S_PC, 32'h80, "trap_vector_pc");
        exp_next(S_MT, 0, "trap_exit");
        tick();

        instruction = NOP; trap_vector = 32'h200;
        exp_next(S_PC, 32'h84, "ack_in_run_ignored");
        tick();
        trap_ack = 1'b0;

        instruction = enc_b(16, 3'b000); rs1_data = 10; rs2_data = 10; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_now(S_BT, 1, "stall_taken_comb");
            exp_next(S_PC, 32'h84, "stall_hold_pc");
            tick();
        end
        stall = 1'b0;
        exp_next(S_PC, 32'h94, "stall_release_pc");
        tick();

        instruction = enc_b(6, 3'b000); stall = 1'b1;
        exp_next(S_PC, 32'h94, "stall_vs_trap_pc");
        exp_next(S_MT, 0, "stall_vs_trap");
        tick();
        stall = 1'b0;
        exp_next(S_MT, 1, "trap_after_stall");
        exp_next(S_TPC, 32'h94, "trap_pc_after_stall");
        tick();

        reset = 1'b0; trap_ack = 1'b1; trap_vector = 32'h300;
        exp_next(S_PC, 0, "reset_in_trap_pc");
        exp_next(S_MT, 0, "reset_in_trap");
        exp_next(S_TPC, 0, "reset_in_trap_tpc");
        tick();
        reset = 1'b1; trap_ack = 1'b0;

        instruction = enc_b(16, 3'b000); rs1_data = 10; rs2_data = 10;
        exp_now(S_IL, 0, "st_beq_legal");
        exp_next(S_PC, 16, "st_beq_pc");
        tick();
        instruction = enc_b(16, 3'b001); rs1_data = 7; rs2_data = 7;
        exp_now(S_IL, 0, "st_bne_legal");
        exp_next(S_PC, 20, "st_bne_pc");
        tick();
        instruction = enc_b(16, 3'b101); rs1_data = 32'hFFFF_FFF8; rs2_data = 3;
        exp_now(S_BT, 0, "bge_not_taken");
        exp_next(S_PC, 24, "st_bge_pc");
        tick();
        instruction = enc_b(8, 3'b111);
        exp_now(S_BT, 1, "bgeu_taken");
        exp_next(S_PC, 32, "st_bgeu_pc");
        tick();
        instruction = enc_b(8, 3'b001); rs1_data = 1; rs2_data = 2;
        exp_now(S_IL, 0, "st_bne2_legal");
        exp_next(S_PC, 40, "st_bne2_pc");
        tick();
        instruction = enc_b(8, 3'b010); rs1_data = 1; rs2_data = 1;
        exp_now(S_IL, 1, "illegal_f3_010");
        exp_now(S_BT, 0, "illegal_not_taken");
        exp_next(S_PC, 44, "illegal_pc");
`ifdef BRANCH_STATS_EN
        exp_next(S_BC, 5, "branch_count");
        exp_next(S_TC, 3, "taken_count");
`endif
        tick();

        instruction = enc_i(8); rs1_data = 32'hFFFF_FFFC;
        exp_now(S_IL, 0, "illegal_pulse_end");
        exp_next(S_PC, 4, "jalr_wrap_pc");
        tick();

        instruction = enc_b(16, 3'b011);
        exp_now(S_IL, 1, "illegal_f3_011");
        exp_next(S_PC, 8, "illegal_011_pc");
        tick();
        instruction = NOP;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
            n_bad += sb.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
